// File: rtl/sprite_layer_engine.sv
// Sprite overlay: per-slot shadow/active descriptors swapped at frame end, plus a
// registered pixel sample feeding a two-stage hit/priority/address pipeline.
module sprite_layer_engine #(
  parameter int NUM_SLOTS    = 8,
  parameter int SIZE_X       = 10,
  parameter int SIZE_Y       = 9,
  parameter int SPRITE_DIM   = 20,
  parameter int SIZE_ADDRESS = 17
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
  input  logic [31:0]                  data_reg,
  input  logic                         pixel_tick,
  input  logic                         active_area,
  input  logic [SIZE_X-1:0]            pixel_x,
  input  logic [SIZE_Y-1:0]            pixel_y,
  input  logic                         count_finished,
  output logic                         sprite_on,
  output logic [SIZE_ADDRESS-1:0]      memory_address,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_id,
  output logic                         collision,
  output logic                         printtingScreen
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int DW = 29;
  localparam logic [31:0]     NS_C   = 32'(NUM_SLOTS);
  localparam logic [31:0]     DIM_C  = 32'(SPRITE_DIM);
  localparam logic [31:0]     DD_C   = 32'(SPRITE_DIM * SPRITE_DIM);
  localparam logic [SIZE_X:0] DIM_XC = (SIZE_X+1)'(SPRITE_DIM);
  localparam logic [SIZE_Y:0] DIM_YC = (SIZE_Y+1)'(SPRITE_DIM);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [DW-1:0]        shadow_q [NUM_SLOTS];
  logic [DW-1:0]        active_q [NUM_SLOTS];

  logic                 a_valid_q, a_active_q;
  logic [SIZE_X-1:0]    a_px_q;
  logic [SIZE_Y-1:0]    a_py_q;

  logic                 b_valid_q, b_hit_q, b_multi_q;
  logic [SW-1:0]        b_slot_q;
  logic [SIZE_X-1:0]    b_lx_q;
  logic [SIZE_Y-1:0]    b_ly_q;
  logic [8:0]           b_off_q;

  logic                 sprite_on_q, collision_q;
  logic [SIZE_ADDRESS-1:0] addr_q;
  logic [SW-1:0]        slot_q;

  logic [NUM_SLOTS-1:0] hit;
  logic                 any_d, multi_d;
  logic [SW-1:0]        win_d;
  logic [DW-1:0]        win_desc;
  logic [SIZE_X-1:0]    lx_d;
  logic [SIZE_Y-1:0]    ly_d;
  logic [31:0]          addr_full;
  logic                 unused_hi;

  assign unused_hi = ^data_reg[31:29];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (count_finished) state_q <= RUN;
      if (wr_en && (32'(wr_slot) < NS_C)) shadow_q[wr_slot] <= data_reg[DW-1:0];
      // The frame-end copy bypasses a same-cycle write so it is never lost.
      if (count_finished) begin
        for (int i = 0; i < NUM_SLOTS; i++)
          active_q[i] <= (wr_en && wr_slot == SW'(i)) ? data_reg[DW-1:0] : shadow_q[i];
      end
    end
  end

  // Bounds are one bit wider than the field so sprites near the edge never wrap.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
      logic [SIZE_X-1:0] sx;
      logic [SIZE_Y-1:0] sy;
      assign sx = active_q[gi][SIZE_X-1:0];
      assign sy = active_q[gi][SIZE_X+SIZE_Y-1:SIZE_X];
      assign hit[gi] = active_q[gi][28]
                    && ({1'b0, a_px_q} >= {1'b0, sx}) && ({1'b0, a_px_q} < ({1'b0, sx} + DIM_XC))
                    && ({1'b0, a_py_q} >= {1'b0, sy}) && ({1'b0, a_py_q} < ({1'b0, sy} + DIM_YC));
    end
  endgenerate

  always_comb begin
    any_d   = 1'b0;
    multi_d = 1'b0;
    win_d   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        if (any_d) multi_d = 1'b1;
        any_d = 1'b1;
        win_d = SW'(i);
      end
    end
  end

  assign win_desc  = active_q[win_d];
  assign lx_d      = a_px_q - win_desc[SIZE_X-1:0];
  assign ly_d      = a_py_q - win_desc[SIZE_X+SIZE_Y-1:SIZE_X];
  assign addr_full = 32'(b_off_q) * DD_C + 32'(b_ly_q) * DIM_C + 32'(b_lx_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid_q <= 1'b0; a_active_q <= 1'b0; a_px_q <= '0; a_py_q <= '0;
      b_valid_q <= 1'b0; b_hit_q <= 1'b0; b_multi_q <= 1'b0;
      b_slot_q <= '0; b_lx_q <= '0; b_ly_q <= '0; b_off_q <= '0;
      sprite_on_q <= 1'b0; addr_q <= '0; slot_q <= '0; collision_q <= 1'b0;
    end else begin
      a_valid_q <= pixel_tick;
      if (pixel_tick) begin
        a_active_q <= active_area;
        a_px_q     <= pixel_x;
        a_py_q     <= pixel_y;
      end
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_hit_q   <= any_d && a_active_q;
        b_multi_q <= multi_d && a_active_q;
        b_slot_q  <= win_d;
        b_lx_q    <= lx_d;
        b_ly_q    <= ly_d;
        b_off_q   <= win_desc[27:19];
      end
      if (state_q == IDLE) begin
        sprite_on_q <= 1'b0;
        addr_q      <= '0;
        slot_q      <= '0;
      end else if (b_valid_q) begin
        sprite_on_q <= b_hit_q;
        addr_q      <= b_hit_q ? addr_full[SIZE_ADDRESS-1:0] : '0;
        slot_q      <= b_hit_q ? b_slot_q : '0;
      end
      if (count_finished || state_q == IDLE) collision_q <= 1'b0;
      else if (b_valid_q && b_multi_q)       collision_q <= 1'b1;
    end
  end

  assign sprite_on       = sprite_on_q;
  assign memory_address  = addr_q;
  assign slot_id         = slot_q;
  assign collision       = collision_q;
  assign printtingScreen = (state_q == RUN);
endmodule

// File: tb/tb_sprite_layer_engine.sv
// Directed bench for sprite_layer_engine with hand-computed expected outputs.
module tb_sprite_layer_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_slot = '0;
  logic [31:0] data_reg = '0;
  logic        pixel_tick = 1'b0;
  logic        active_area = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [8:0]  pixel_y = '0;
  logic        count_finished = 1'b0;
  logic        sprite_on;
  logic [16:0] memory_address;
  logic [2:0]  slot_id;
  logic        collision;
  logic        printtingScreen;

  int checks = 0;
  int errors = 0;

  sprite_layer_engine dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_slot(wr_slot), .data_reg(data_reg),
    .pixel_tick(pixel_tick), .active_area(active_area), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .count_finished(count_finished), .sprite_on(sprite_on), .memory_address(memory_address),
    .slot_id(slot_id), .collision(collision), .printtingScreen(printtingScreen)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] desc(input int x, input int y, input int off, input bit en);
    logic [31:0] d;
    d = '0;
    d[9:0]   = 10'(x);
    d[18:10] = 9'(y);
    d[27:19] = 9'(off);
    d[28]    = en;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int slot, input logic [31:0] d, input bit cf);
    @(negedge clk);
    wr_en = 1'b1; wr_slot = 3'(slot); data_reg = d; count_finished = cf;
    @(negedge clk);
    wr_en = 1'b0; count_finished = 1'b0;
  endtask

  task automatic frame_end();
    @(negedge clk);
    count_finished = 1'b1;
    @(negedge clk);
    count_finished = 1'b0;
  endtask

  // One tick, then wait through the two pipeline edges; returns at a negedge.
  task automatic tick(input int x, input int y, input bit act);
    @(negedge clk);
    pixel_tick = 1'b1; pixel_x = 10'(x); pixel_y = 9'(y); active_area = act;
    @(negedge clk);
    pixel_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input bit on, input int addr, input int slot);
    chk({tag, ".on"}, 32'(sprite_on), 32'(on));
    chk({tag, ".addr"}, 32'(memory_address), 32'(addr));
    chk({tag, ".slot"}, 32'(slot_id), 32'(slot));
    $display("%s on=%0b addr=%0d slot=%0d coll=%0b run=%0b", tag, sprite_on, memory_address,
             slot_id, collision, printtingScreen);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 0, 0);
    chk("reset.coll", 32'(collision), 32'd0);
    chk("reset.run", 32'(printtingScreen), 32'd0);
    reset = 1'b1;

    // IDLE forces outputs low even with a valid written sprite
    wr(0, desc(100, 50, 2, 1'b1), 1'b0);
    tick(105, 53, 1'b1);
    chk_out("idle", 1'b0, 0, 0);
    chk("idle.run", 32'(printtingScreen), 32'd0);

    // Reset cleared active; first frame end activates the shadow copy
    frame_end();
    chk("run.after_cf", 32'(printtingScreen), 32'd1);
    tick(105, 53, 1'b1);
    chk_out("basic", 1'b1, 865, 0);

    // Shadow-only write must not affect the current frame
    wr(0, desc(300, 300, 2, 1'b1), 1'b0);
    tick(105, 53, 1'b1);
    chk_out("shadow_old", 1'b1, 865, 0);
    frame_end();
    tick(105, 53, 1'b1);
    chk_out("shadow_new", 1'b0, 0, 0);
    wr(0, desc(100, 50, 2, 1'b1), 1'b0);
    tick(105, 53, 1'b1);
    chk_out("shadow_pend", 1'b0, 0, 0);
    frame_end();
    tick(105, 53, 1'b1);
    chk_out("shadow_swap", 1'b1, 865, 0);

    // Edges of the 20x20 box
    tick(119, 69, 1'b1);
    chk_out("edge_in", 1'b1, 1199, 0);
    tick(120, 69, 1'b1);
    chk_out("edge_x", 1'b0, 0, 0);
    tick(100, 70, 1'b1);
    chk_out("edge_y", 1'b0, 0, 0);
    tick(105, 53, 1'b0);
    chk_out("inactive", 1'b0, 0, 0);

    // Address truncation with max offset; same-cycle write included in frame copy
    wr(2, desc(300, 200, 511, 1'b1), 1'b0);
    wr(4, desc(400, 300, 0, 1'b1), 1'b1);
    tick(300, 200, 1'b1);
    chk_out("off511", 1'b1, 73328, 2);
    tick(401, 302, 1'b1);
    chk_out("same_cyc", 1'b1, 41, 4);
    chk("single.coll", 32'(collision), 32'd0);

    // Overlap: lowest index wins, collision sticky until frame end
    wr(1, desc(190, 95, 1, 1'b1), 1'b0);
    wr(3, desc(195, 90, 3, 1'b1), 1'b0);
    frame_end();
    tick(200, 100, 1'b0);
    chk("overlap_inactive.coll", 32'(collision), 32'd0);
    tick(200, 100, 1'b1);
    chk_out("overlap", 1'b1, 510, 1);
    chk("overlap.coll", 32'(collision), 32'd1);
    tick(105, 53, 1'b1);
    chk("coll_sticky", 32'(collision), 32'd1);
    frame_end();
    chk("coll_clear", 32'(collision), 32'd0);

    // Asynchronous reset mid-frame
    tick(105, 53, 1'b1);
    chk_out("pre_rst", 1'b1, 865, 0);
    @(negedge clk);
    pixel_tick = 1'b1; pixel_x = 10'd105; pixel_y = 9'd53; active_area = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 0, 0);
    chk("async_rst.run", 32'(printtingScreen), 32'd0);
    chk("async_rst.coll", 32'(collision), 32'd0);
    @(negedge clk);
    pixel_tick = 1'b0;
    reset = 1'b1;
    wr(0, desc(100, 50, 2, 1'b1), 1'b0);
    tick(105, 53, 1'b1);
    chk_out("post_rst", 1'b0, 0, 0);
    chk("post_rst.run", 32'(printtingScreen), 32'd0);
    frame_end();
    chk("post_rst.cf_run", 32'(printtingScreen), 32'd1);
    tick(105, 53, 1'b1);
    chk_out("post_rst.hit", 1'b1, 865, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
